// File: rtl/if_prefetch_unit_pkg.sv
// Shared RISC-V fetch definitions: default widths, reset PC, NOP encoding and a
// saturating-add helper used by the optional performance counters.
package if_prefetch_unit_pkg;

  localparam int unsigned DefXlen    = 32;
  localparam int unsigned DefPcWidth = 32;
  localparam logic [31:0] DefResetPc = 32'h0000_0000;
  localparam logic [31:0] InstNop    = 32'h0000_0013;

  function automatic logic [31:0] sat_add32(input logic [31:0] a, input logic [31:0] b);
    logic [32:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[32] ? 32'hFFFF_FFFF : sum[31:0];
  endfunction

endpackage

// File: rtl/if_prefetch_unit_if.sv
// Fetch-unit bus bundle: instruction-memory request/response, EX redirect and
// the valid/ready instruction hand-off to ID.
interface if_prefetch_unit_if
  import if_prefetch_unit_pkg::*;
#(
  parameter int unsigned XLEN     = DefXlen,
  parameter int unsigned PC_WIDTH = DefPcWidth
);

  logic                mem_req_o;
  logic [XLEN-1:0]     mem_addr_o;
  logic                mem_gnt_i;
  logic                mem_rvalid_i;
  logic [XLEN-1:0]     mem_rdata_i;
  logic                redirect_i;
  logic [PC_WIDTH-1:0] redirect_pc_i;
  logic                inst_valid_o;
  logic                inst_ready_i;
  logic [XLEN-1:0]     inst_o;
  logic [PC_WIDTH-1:0] pc_o;
  logic [PC_WIDTH-1:0] pcplus4_o;

  modport master (
    output mem_req_o, mem_addr_o,
    input  mem_gnt_i, mem_rvalid_i, mem_rdata_i,
    input  redirect_i, redirect_pc_i,
    output inst_valid_o, inst_o, pc_o, pcplus4_o,
    input  inst_ready_i
  );

  modport slave (
    input  mem_req_o, mem_addr_o,
    output mem_gnt_i, mem_rvalid_i, mem_rdata_i,
    output redirect_i, redirect_pc_i,
    input  inst_valid_o, inst_o, pc_o, pcplus4_o,
    output inst_ready_i
  );

endinterface

// File: rtl/if_prefetch_unit_fifo.sv
// Synchronous prefetch queue holding {pc, inst}; a flush empties it in one
// cycle and takes priority over push and pop.
module if_fifo #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] DepthW = (AW + 1)'(DEPTH);

  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             full, do_push, do_pop;

  assign full    = (count_q == DepthW);
  assign empty   = (count_q == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign count   = count_q;
  assign rdata   = mem_q[rd_ptr_q];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_q + (AW + 1)'(do_push) - (AW + 1)'(do_pop);
    end
  end

  // Storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/if_prefetch_unit.sv
// Instruction prefetch unit: credit-limited sequential fetch, in-order response
// queue, redirect flush with stale-response dropping. IF_PERF_CNT_EN adds counters.
module if_prefetch_unit
  import if_prefetch_unit_pkg::*;
#(
  parameter int unsigned         XLEN     = DefXlen,
  parameter int unsigned         PC_WIDTH = DefPcWidth,
  parameter int unsigned         DEPTH    = 4,
  parameter logic [PC_WIDTH-1:0] RESET_PC = PC_WIDTH'(DefResetPc)
) (
  input  logic               clk,
  input  logic               rst,
  if_prefetch_unit_if.master bus
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0]        stall_cycles_o,
  output logic [31:0]        empty_cycles_o,
  output logic [31:0]        dropped_o
`endif
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam logic [CW:0] DepthW = (CW + 1)'(DEPTH);
  localparam logic [PC_WIDTH-1:0] AlignMask = ~PC_WIDTH'(3);

  logic [PC_WIDTH-1:0]      fetch_pc_q, fetch_pc_d;
  logic [PC_WIDTH-1:0]      resp_pc_q, resp_pc_d;
  logic [CW-1:0]            outstanding_q, outstanding_d;
  logic [CW-1:0]            drop_q, drop_d;
  logic [CW-1:0]            fifo_count;
  logic [CW:0]              credit_sum;
  logic [PC_WIDTH+XLEN-1:0] fifo_head;
  logic                     fifo_empty;
  logic [PC_WIDTH-1:0]      redirect_pc;
  logic                     mem_req, grant, resp, resp_drop, push, pop;

  assign redirect_pc = bus.redirect_pc_i & AlignMask;
  assign credit_sum  = {1'b0, fifo_count} + {1'b0, outstanding_q};
  // Queued plus in-flight words never exceed DEPTH, so a response always fits.
  assign mem_req     = ~rst & ~bus.redirect_i & (credit_sum < DepthW);
  assign grant       = mem_req & bus.mem_gnt_i;
  assign resp        = bus.mem_rvalid_i & (outstanding_q != '0);
  // Responses landing in the redirect cycle belong to the old stream.
  assign resp_drop   = resp & ((drop_q != '0) | bus.redirect_i);
  assign push        = resp & ~resp_drop;
  assign pop         = ~fifo_empty & bus.inst_ready_i & ~bus.redirect_i;

  always_comb begin
    outstanding_d = outstanding_q + CW'(grant) - CW'(resp);
    drop_d        = drop_q - CW'(resp & (drop_q != '0));
    fetch_pc_d    = fetch_pc_q;
    resp_pc_d     = resp_pc_q;
    if (bus.redirect_i) begin
      // Everything still in flight after this cycle is stale.
      drop_d     = outstanding_d;
      fetch_pc_d = redirect_pc;
      resp_pc_d  = redirect_pc;
    end else begin
      if (grant) fetch_pc_d = fetch_pc_q + PC_WIDTH'(4);
      if (push)  resp_pc_d  = resp_pc_q + PC_WIDTH'(4);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc_q    <= RESET_PC & AlignMask;
      resp_pc_q     <= RESET_PC & AlignMask;
      outstanding_q <= '0;
      drop_q        <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      resp_pc_q     <= resp_pc_d;
      outstanding_q <= outstanding_d;
      drop_q        <= drop_d;
    end
  end

  if_fifo #(
    .WIDTH(PC_WIDTH + XLEN),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .flush(bus.redirect_i),
    .push (push),
    .wdata({resp_pc_q, bus.mem_rdata_i}),
    .pop  (pop),
    .rdata(fifo_head),
    .empty(fifo_empty),
    .count(fifo_count)
  );

  assign bus.mem_req_o    = mem_req;
  assign bus.mem_addr_o   = XLEN'(fetch_pc_q & AlignMask);
  assign bus.inst_valid_o = ~fifo_empty;
  assign bus.inst_o       = fifo_empty ? XLEN'(InstNop) : fifo_head[XLEN-1:0];
  assign bus.pc_o         = fifo_head[XLEN +: PC_WIDTH];
  assign bus.pcplus4_o    = fifo_head[XLEN +: PC_WIDTH] + PC_WIDTH'(4);

`ifdef IF_PERF_CNT_EN
  logic [31:0] stall_q, empty_q, dropped_q, dropped_inc;

  // A flush discards every queued entry; the redirect-cycle dequeue is ignored.
  assign dropped_inc = 32'(resp_drop) + (bus.redirect_i ? 32'(fifo_count) : 32'd0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_q   <= '0;
      empty_q   <= '0;
      dropped_q <= '0;
    end else begin
      stall_q   <= sat_add32(stall_q, 32'(~fifo_empty & ~bus.inst_ready_i));
      empty_q   <= sat_add32(empty_q, 32'(fifo_empty));
      dropped_q <= sat_add32(dropped_q, dropped_inc);
    end
  end

  assign stall_cycles_o = stall_q;
  assign empty_cycles_o = empty_q;
  assign dropped_o      = dropped_q;
`endif

endmodule

// File: tb/tb_if_prefetch_unit.sv
// Self-checking bench for if_prefetch_unit: in-order random-latency memory model
// plus a PC-stream reference (expected fetch address and expected next instruction).
module tb_if_prefetch_unit;

  localparam int unsigned Depth = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  if_prefetch_unit_if #(.XLEN(32), .PC_WIDTH(32)) bus ();

`ifdef IF_PERF_CNT_EN
  logic [31:0] stall_cycles, empty_cycles, dropped;
`endif

  if_prefetch_unit #(
    .XLEN    (32),
    .PC_WIDTH(32),
    .DEPTH   (Depth),
    .RESET_PC(32'h0)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
`ifdef IF_PERF_CNT_EN
    ,
    .stall_cycles_o(stall_cycles),
    .empty_cycles_o(empty_cycles),
    .dropped_o     (dropped)
`endif
  );

  typedef struct {
    logic [31:0] addr;
    int          due;
  } mreq_t;

  mreq_t       memq[$];
  int          n_pass = 0;
  int          n_total = 0;
  int          cyc;
  int          lat_min, lat_max;
  logic [31:0] exp_fetch, exp_pc;
  logic        drv_gnt, drv_ready, drv_redirect;
  logic [31:0] drv_target;
  logic        s_req, s_grant, s_valid, s_accept, s_rvalid;
  logic [31:0] s_addr, s_pc, s_pc4, s_inst;
  logic        hold_prev;
  logic [31:0] hold_pc;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {~a[15:0], a[15:0]} ^ 32'h3C00_0013;
  endfunction

  // One clock cycle: present memory response and controls, sample, update model.
  task automatic step();
    mreq_t       r;
    logic [31:0] tgt;
    @(negedge clk);
    if (memq.size() > 0 && memq[0].due <= cyc) begin
      r = memq.pop_front();
      bus.mem_rvalid_i = 1'b1;
      bus.mem_rdata_i  = mem_word(r.addr);
    end else begin
      bus.mem_rvalid_i = 1'b0;
      bus.mem_rdata_i  = $urandom;
    end
    s_rvalid          = bus.mem_rvalid_i;
    bus.mem_gnt_i     = drv_gnt;
    bus.inst_ready_i  = drv_ready;
    bus.redirect_i    = drv_redirect;
    bus.redirect_pc_i = drv_target;
    #1;
    s_req    = bus.mem_req_o;
    s_addr   = bus.mem_addr_o;
    s_valid  = bus.inst_valid_o;
    s_pc     = bus.pc_o;
    s_pc4    = bus.pcplus4_o;
    s_inst   = bus.inst_o;
    s_grant  = s_req & drv_gnt;
    s_accept = s_valid & drv_ready & ~drv_redirect;
    if (hold_prev) begin
      n_total++;
      if ({s_valid, s_pc} !== {1'b1, hold_pc})
        $display("FAIL hold_while_stalled: got valid=%b pc=%h expected valid=1 pc=%h",
                 s_valid, s_pc, hold_pc);
      else n_pass++;
    end
    if (drv_redirect) begin
      n_total++;
      if (s_req !== 1'b0) $display("FAIL req_in_redirect: got %b expected 0", s_req);
      else n_pass++;
    end
    if (s_grant) begin
      n_total++;
      if (s_addr !== exp_fetch)
        $display("FAIL fetch_addr: got %h expected %h", s_addr, exp_fetch);
      else n_pass++;
      memq.push_back('{s_addr, cyc + int'($urandom_range(lat_max, lat_min))});
      exp_fetch += 32'd4;
    end
    n_total++;
    if (memq.size() > Depth) $display("FAIL credit: got %0d outstanding expected <= %0d",
                                      memq.size(), Depth);
    else n_pass++;
    if (s_accept) begin
      n_total++;
      if ({s_pc, s_inst, s_pc4} !== {exp_pc, mem_word(exp_pc), exp_pc + 32'd4})
        $display("FAIL inst_stream: got pc=%h inst=%h pc4=%h expected pc=%h inst=%h pc4=%h",
                 s_pc, s_inst, s_pc4, exp_pc, mem_word(exp_pc), exp_pc + 32'd4);
      else n_pass++;
      exp_pc += 32'd4;
    end
    if (drv_redirect) begin
      tgt       = drv_target & ~32'h3;
      exp_fetch = tgt;
      exp_pc    = tgt;
    end
    hold_prev = s_valid & ~drv_ready & ~drv_redirect;
    hold_pc   = s_pc;
    cyc++;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst               = 1'b1;
    bus.mem_gnt_i     = 1'b0;
    bus.mem_rvalid_i  = 1'b0;
    bus.mem_rdata_i   = '0;
    bus.redirect_i    = 1'b0;
    bus.redirect_pc_i = '0;
    bus.inst_ready_i  = 1'b0;
    drv_gnt = 1'b0; drv_ready = 1'b0; drv_redirect = 1'b0; drv_target = '0;
    memq.delete();
    #1;
    n_total++;
    if ({bus.mem_req_o, bus.inst_valid_o} !== 2'b00)
      $display("FAIL reset_outputs: got req=%b valid=%b expected 0 0",
               bus.mem_req_o, bus.inst_valid_o);
    else n_pass++;
    repeat (2) @(negedge clk);
    rst       = 1'b0;
    exp_fetch = 32'h0;
    exp_pc    = 32'h0;
    cyc       = 0;
    hold_prev = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    lat_min = 1; lat_max = 1;
    step();
    n_total++;
    if ({s_req, s_addr, s_valid} !== {1'b1, 32'h0, 1'b0})
      $display("FAIL post_reset: got req=%b addr=%h valid=%b expected 1 00000000 0",
               s_req, s_addr, s_valid);
    else n_pass++;
  endtask

  task automatic test_stream();
    int          first_grant, first_valid;
    logic        v_arr[16];
    logic [31:0] p_arr[16];
    apply_reset();
    drv_gnt = 1'b1; drv_ready = 1'b1; lat_min = 1; lat_max = 1;
    first_grant = -1; first_valid = -1;
    for (int i = 0; i < 16; i++) begin
      step();
      v_arr[i] = s_valid;
      p_arr[i] = s_pc;
      if (s_grant && first_grant < 0) first_grant = i;
      if (s_valid && first_valid < 0) first_valid = i;
    end
    n_total++;
    if (first_grant < 0 || first_valid - first_grant != 2)
      $display("FAIL grant_to_valid: got grant@%0d valid@%0d expected 2 cycles apart",
               first_grant, first_valid);
    else n_pass++;
    n_total++;
    if (first_valid < 0 || first_valid > 8) begin
      $display("FAIL stream_start: got first valid at %0d expected <= 8", first_valid);
    end else begin
      n_pass++;
      for (int k = 0; k < 6; k++) begin
        n_total++;
        if ({v_arr[first_valid+k], p_arr[first_valid+k]} !== {1'b1, 32'(4 * k)})
          $display("FAIL back_to_back: got valid=%b pc=%h expected valid=1 pc=%h",
                   v_arr[first_valid+k], p_arr[first_valid+k], 32'(4 * k));
        else n_pass++;
      end
    end
  endtask

  task automatic test_stall();
    int          grants, accepted;
    logic        resumed;
    logic [31:0] pcs[4];
    apply_reset();
    drv_gnt = 1'b1; drv_ready = 1'b0; lat_min = 1; lat_max = 1;
    grants = 0;
    repeat (10) begin
      step();
      if (s_grant) grants++;
    end
    n_total++;
    if (grants != 4) $display("FAIL stall_grants: got %0d expected 4", grants);
    else n_pass++;
    n_total++;
    if ({s_req, s_valid, s_pc} !== {1'b0, 1'b1, 32'h0})
      $display("FAIL stall_state: got req=%b valid=%b pc=%h expected 0 1 00000000",
               s_req, s_valid, s_pc);
    else n_pass++;
    drv_ready = 1'b1;
    accepted  = 0;
    resumed   = 1'b0;
    for (int i = 0; i < 20 && accepted < 4; i++) begin
      step();
      if (s_grant) resumed = 1'b1;
      if (s_accept) begin
        pcs[accepted] = s_pc;
        accepted++;
      end
    end
    n_total++;
    if (accepted != 4) $display("FAIL drain_count: got %0d expected 4", accepted);
    else n_pass++;
    for (int k = 0; k < accepted; k++) begin
      n_total++;
      if (pcs[k] !== 32'(4 * k)) $display("FAIL drain_order: got %h expected %h",
                                         pcs[k], 32'(4 * k));
      else n_pass++;
    end
    n_total++;
    if (!resumed) $display("FAIL req_resume: got no grant expected a grant after release");
    else n_pass++;
  endtask

  task automatic test_redirect_drop();
    logic got;
    apply_reset();
    drv_gnt = 1'b1; drv_ready = 1'b1; lat_min = 3; lat_max = 3;
    step();
    step();
    n_total++;
    if (memq.size() != 2) $display("FAIL outstanding_before_redirect: got %0d expected 2",
                                   memq.size());
    else n_pass++;
    drv_redirect = 1'b1; drv_target = 32'h100;
    step();
    drv_redirect = 1'b0;
    step();
    n_total++;
    if ({s_grant, s_addr} !== {1'b1, 32'h100})
      $display("FAIL redirect_fetch: got grant=%b addr=%h expected 1 00000100", s_grant, s_addr);
    else n_pass++;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      step();
      if (s_accept) got = 1'b1;
    end
    n_total++;
    if (!got || s_pc !== 32'h100)
      $display("FAIL redirect_first_pc: got valid=%b pc=%h expected 1 00000100", got, s_pc);
    else n_pass++;
  endtask

  task automatic test_redirect_same_cycle();
    logic got;
    apply_reset();
    drv_gnt = 1'b1; drv_ready = 1'b1; lat_min = 1; lat_max = 1;
    repeat (3) step();
    drv_redirect = 1'b1; drv_target = 32'h203;
    step();
    drv_redirect = 1'b0;
    step();
    n_total++;
    if ({s_grant, s_addr} !== {1'b1, 32'h200})
      $display("FAIL unaligned_redirect_addr: got grant=%b addr=%h expected 1 00000200",
               s_grant, s_addr);
    else n_pass++;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      step();
      if (s_accept) got = 1'b1;
    end
    n_total++;
    if (!got || {s_pc, s_pc4} !== {32'h200, 32'h204})
      $display("FAIL unaligned_redirect_head: got pc=%h pc4=%h expected 00000200 00000204",
               s_pc, s_pc4);
    else n_pass++;
  endtask

  task automatic test_wrap();
    logic saw_zero;
    apply_reset();
    drv_gnt = 1'b1; drv_ready = 1'b1; lat_min = 1; lat_max = 2;
    step();
    drv_redirect = 1'b1; drv_target = 32'hFFFF_FFF8;
    step();
    drv_redirect = 1'b0;
    saw_zero = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (s_accept && s_pc == 32'h0) saw_zero = 1'b1;
    end
    n_total++;
    if (!saw_zero) $display("FAIL pc_wrap: got no pc 00000000 expected wrap after FFFFFFFC");
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    apply_reset();
    drv_gnt = 1'b1; drv_ready = 1'b0; lat_min = 2; lat_max = 2;
    repeat (5) step();
    n_total++;
    if (s_valid !== 1'b1) $display("FAIL prefill_valid: got %b expected 1", s_valid);
    else n_pass++;
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    n_total++;
    if ({bus.mem_req_o, bus.inst_valid_o} !== 2'b00)
      $display("FAIL async_reset: got req=%b valid=%b expected 0 0",
               bus.mem_req_o, bus.inst_valid_o);
    else n_pass++;
    apply_reset();
    drv_gnt = 1'b1;
    step();
    n_total++;
    if ({s_grant, s_addr} !== {1'b1, 32'h0})
      $display("FAIL restart_addr: got grant=%b addr=%h expected 1 00000000", s_grant, s_addr);
    else n_pass++;
  endtask

  task automatic test_random();
    apply_reset();
    lat_min = 1; lat_max = 4;
    for (int i = 0; i < 3000; i++) begin
      drv_gnt      = ($urandom_range(3, 0) != 0);
      drv_ready    = ($urandom_range(3, 0) != 0);
      drv_redirect = ($urandom_range(39, 0) == 0);
      drv_target   = $urandom & 32'h0003_FFFF;
      step();
    end
    drv_redirect = 1'b0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_redirect_drop();
    test_redirect_same_cycle();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
